pool_window_buffer: RTL and testbench
=====================================

POOL_WINDOW_BUFFER -- requirements
Module: pool_window_buffer

Interface
REQ-001 SHALL have parameter data_width, default 8, pixel width in bits.
REQ-002 SHALL have parameter pooling_units, default 4, number of windows emitted in parallel.
REQ-003 SHALL have parameters K (default 2, window side) and S (default 2, stride); only K == S is supported.
REQ-004 SHALL have localparam W = pooling_units*S, pixels per buffered row.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 flush  input  1  synchronous clear that discards a partial window set.
REQ-008 in_valid  input  1  in_data holds a valid pixel.
REQ-009 in_ready  output  1  block accepts a pixel this cycle.
REQ-010 in_data  input  data_width  raster-order pixel, row-major, W pixels per row.
REQ-011 out_valid  output  1  window set valid; drives the pooling stage's start_pool.
REQ-012 out_ready  input  1  pooling stage consumes the window set.
REQ-013 pooling_in  output  [pooling_units][K*S] x data_width  window set for the pooling stage.

Function
REQ-014 SHALL accept a pixel on a cycle where in_valid && in_ready.
REQ-015 SHALL track the column counter col (0..W-1) and the row counter row (0..K-1), and advance them on each accepted pixel.
REQ-016 SHALL store the pixel accepted at (row r, col c) in pooling_in[c/S][r*K + c%S].
REQ-017 SHALL implement two states: FILL and EMIT.
REQ-018 FILL: in_ready = 1 and out_valid = 0.
REQ-019 FILL -> EMIT on acceptance of the pixel at row = K-1, col = W-1; counters wrap to 0.
REQ-020 EMIT: out_valid = 1; pooling_in holds its values until the handshake completes.
REQ-021 EMIT: in_ready = out_ready, giving zero-bubble back-to-back operation.
REQ-022 EMIT -> FILL on out_valid && out_ready.
REQ-023 A pixel accepted on the handshake cycle SHALL be written to row 0, col 0; pooling_in SHALL show the old value up to and including that edge.
REQ-024 Latency: out_valid SHALL rise on the clock edge that accepts the final pixel of a window set, i.e. 0 additional cycles.
REQ-025 flush SHALL force FILL and clear both counters; it SHALL take priority over in_valid and over the handshake; buffer contents are don't-care.
REQ-026 SHALL drop no pixel under arbitrary in_valid/out_ready patterns.
REQ-027 in_data SHALL be stored unmodified: no arithmetic, no width change.

Reset
REQ-028 rst asserted SHALL immediately force state FILL, row = 0, col = 0, out_valid = 0, and all pooling_in elements to 0.
REQ-029 in_ready SHALL read 1 while in reset and in the cycle after release.
REQ-030 rst asserted mid-fill or mid-EMIT SHALL abandon the window set; the first pixel after release is stored at row 0, col 0.

Structure
REQ-031 A shared package SHALL hold the FILL/EMIT state enum and the default data_width, pooling_units, K and S values used by this block and by pooling_layer.
REQ-032 The block SHALL be a single module with no sub-modules; the output array is the storage itself.
REQ-033 The block SHALL connect to pooling_layer as out_valid->start_pool and pooling_in->pooling_in, with identical parameters.

Verification
REQ-034 Reset then stream pixels 1..16 with in_valid held high and out_ready = 0 -> out_valid = 1 after pixel 16; pooling_in[0] = {1,2,9,10}, pooling_in[3] = {7,8,15,16} (index 0..3); in_ready = 0.
REQ-035 Hold out_ready = 0 for 5 cycles during EMIT with in_valid = 1 -> outputs unchanged and no pixel accepted; then pulse out_ready -> out_valid falls next cycle.
REQ-036 Stream 1..32 continuously with out_ready = 1 -> two window sets; the second gives pooling_in[0] = {17,18,25,26}; pixel 17 is accepted on the first handshake cycle with no bubble.
REQ-037 Stream 1..5, assert flush, then stream 101..116 -> pooling_in[0] = {101,102,109,110}.
REQ-038 Assert rst mid-EMIT and again mid-fill -> out_valid = 0 and pooling_in all 0 immediately; the next 16 pixels form a correct set.
REQ-039 Random in_valid/out_ready for 1000 pixels against a scoreboard model -> every window set matches and no pixel is lost.

Source files
------------

// File: rtl/pool_window_buffer_pkg.sv
// Shared types and default geometry for the pooling front end (window buffer and pooling_layer).
package pool_window_buffer_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    EMIT = 1'b1
  } pwb_state_e;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_POOLING_UNITS = 4;
  localparam int DEF_K             = 2;
  localparam int DEF_S             = 2;

endpackage

// File: rtl/pool_window_buffer.sv
// Collects K raster rows of W pixels into pooling_units KxS windows and hands the set
// to the pooling stage with a valid/ready handshake; the output array is the storage.
module pool_window_buffer
  import pool_window_buffer_pkg::*;
#(
  parameter int data_width    = DEF_DATA_WIDTH,
  parameter int pooling_units = DEF_POOLING_UNITS,
  parameter int K             = DEF_K,
  parameter int S             = DEF_S
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             flush,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [data_width-1:0]                            in_data,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [pooling_units-1:0][K*S-1:0][data_width-1:0] pooling_in
);

  localparam int W     = pooling_units * S;
  localparam int COL_W = (W > 1) ? $clog2(W) : 1;
  localparam int ROW_W = (K > 1) ? $clog2(K) : 1;

  pwb_state_e state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [pooling_units-1:0][K*S-1:0][data_width-1:0] pool_q, pool_d;

  logic accept;
  logic last_pix;
  int   unit_idx;
  int   elem_idx;

  // In EMIT a new pixel may only enter on the handshake cycle, so the set never overruns.
  assign out_valid  = (state_q == EMIT);
  assign in_ready   = (state_q == FILL) ? 1'b1 : out_ready;
  assign accept     = in_valid && in_ready;
  assign pooling_in = pool_q;

  // Next-state, counter and window-storage update.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    pool_d   = pool_q;
    unit_idx = int'(col_q) / S;
    elem_idx = int'(row_q) * K + int'(col_q) % S;
    last_pix = (col_q == COL_W'(W - 1)) && (row_q == ROW_W'(K - 1));

    if (flush) begin
      state_d = FILL;
      col_d   = '0;
      row_d   = '0;
    end else begin
      if (accept) begin
        for (int u = 0; u < pooling_units; u++) begin
          for (int e = 0; e < K * S; e++) begin
            pool_d[u][e] = ((unit_idx == u) && (elem_idx == e)) ? in_data : pool_q[u][e];
          end
        end
        if (col_q == COL_W'(W - 1)) begin
          col_d = '0;
          row_d = (row_q == ROW_W'(K - 1)) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end else begin
        col_d = col_q;
      end

      case (state_q)
        FILL: begin
          if (accept && last_pix) begin
            state_d = EMIT;
          end else begin
            state_d = FILL;
          end
        end
        EMIT: begin
          if (out_ready) begin
            state_d = (accept && last_pix) ? EMIT : FILL;
          end else begin
            state_d = EMIT;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State, counters and window storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      pool_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pool_q  <= pool_d;
    end
  end

endmodule

// File: tb/tb_pool_window_buffer.sv
// Directed and random checks of pool_window_buffer against an ordered-pixel reference model.
module tb_pool_window_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_data = 8'd0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [3:0][3:0][7:0] pooling_in;

  int total = 0;
  int bad = 0;

  // Reference model: pixels of the set being filled, in arrival order, and the set on offer.
  logic [7:0] m_cur [16];
  logic [7:0] m_set [16];
  int m_n = 0;
  bit m_emit = 1'b0;
  int accepted = 0;

  pool_window_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .pooling_in(pooling_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel p of a set sits at row p/8, col p%8 and lands in window col/2, element row*2 + col%2.
  function automatic logic [127:0] exp_pool(input logic [7:0] s [16]);
    logic [3:0][3:0][7:0] e;
    e = '0;
    for (int p = 0; p < 16; p++) begin
      e[2'(((p % 8) / 2))][2'((p / 8) * 2 + (p % 8) % 2)] = s[4'(p)];
    end
    return e;
  endfunction

  task automatic cycle(input bit v, input logic [7:0] d, input bit r, input bit f);
    bit exp_rdy, acc, hs;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = r; flush = f;
    #1;
    exp_rdy = !m_emit || r;
    chk("out_valid", out_valid, m_emit);
    chk("in_ready", in_ready, exp_rdy);
    if (m_emit) chk("pooling_in", pooling_in, exp_pool(m_set));
    acc = v && exp_rdy;
    hs  = m_emit && r;
    @(posedge clk);
    if (f) begin
      m_emit = 1'b0;
      m_n = 0;
    end else begin
      if (hs) m_emit = 1'b0;
      if (acc) begin
        m_cur[4'(m_n)] = d;
        m_n++;
        accepted++;
        if (m_n == 16) begin
          m_set = m_cur;
          m_emit = 1'b1;
          m_n = 0;
        end
      end
    end
  endtask

  // Idle inputs for one cycle and leave the caller sampling mid-cycle.
  task automatic sample();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = 8'd0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_pool_zero", pooling_in, 128'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    m_emit = 1'b0;
    m_n = 0;
  endtask

  initial begin
    int base;
    int cyc;
    #3;
    do_reset();

    // Single set with consumer stalled.
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    sample();
    chk("set1_out_valid", out_valid, 1'b1);
    chk("set1_unit0", pooling_in[0], {8'd10, 8'd9, 8'd2, 8'd1});
    chk("set1_unit3", pooling_in[3], {8'd16, 8'd15, 8'd8, 8'd7});
    chk("set1_in_ready", in_ready, 1'b0);

    // Stalled EMIT with pixels offered, then one handshake.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    sample();
    chk("drain_out_valid", out_valid, 1'b0);

    // Back-to-back sets with the consumer always ready.
    base = accepted;
    for (int i = 1; i <= 32; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
    chk("b2b_no_bubble", 128'(accepted - base), 128'd32);
    sample();
    chk("set2_unit0", pooling_in[0], {8'd26, 8'd25, 8'd18, 8'd17});
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush discards a partial set.
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    for (int i = 101; i <= 116; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    sample();
    chk("flush_unit0", pooling_in[0], {8'd110, 8'd109, 8'd102, 8'd101});
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-EMIT, then mid-fill.
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i + 50), 1'b0, 1'b0);
    do_reset();
    for (int i = 1; i <= 7; i++) cycle(1'b1, 8'(i + 70), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(200 + i), 1'b0, 1'b0);
    sample();
    chk("rst_refill_unit0", pooling_in[0], {8'd209, 8'd208, 8'd201, 8'd200});
    chk("rst_refill_unit2", pooling_in[2], {8'd213, 8'd212, 8'd205, 8'd204});
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic against the model.
    base = accepted;
    cyc = 0;
    while ((accepted - base) < 1000 && cyc < 20000) begin
      cycle(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 2) != 0), 1'b0);
      cyc++;
    end
    chk("random_pixel_count", 128'(accepted - base), 128'd1000);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
